// File: rtl/tv_656_decoder.sv
// Purpose: BT.656 timing decoder; recovers F/V/H from EAV/SAV codes and extracts active luma with x/y indices.
// Latency: pixel byte sampled at edge k is emitted after edge k+4; timing outputs update at the code-byte edge.
// Backpressure: none; the byte stream is consumed every cycle and the outputs cannot be stalled.
module tv_656_decoder #(
    parameter int X_MAX = 1023,
    parameter int Y_MAX = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] td_data,
    output logic       pix_valid,
    output logic [7:0] pix_y,
    output logic [9:0] tv_x,
    output logic [9:0] tv_y,
    output logic       field,
    output logic       v_blank,
    output logic       line_active,
    output logic       sync_err
);

    localparam logic [9:0] X_SAT = 10'(X_MAX);
    localparam logic [9:0] Y_SAT = 10'(Y_MAX);

    // Delay line: d0 is the newest byte, d3 the oldest; a* marks bytes belonging to an active line.
    logic [7:0] d0, d1, d2, d3;
    logic       a0, a1, a2, a3;

    logic [1:0] phase;
    logic [9:0] x_cnt;
    logic       y_clr_pend;

    logic code_det;
    logic code_ok;
    logic code_f;
    logic code_v;
    logic code_h;
    logic sav_start;

    // Preamble detection and protection-bit check on the incoming code byte.
    always_comb begin
        code_det  = (d2 == 8'hFF) && (d1 == 8'h00) && (d0 == 8'h00);
        code_f    = td_data[6];
        code_v    = td_data[5];
        code_h    = td_data[4];
        code_ok   = td_data[7]
                    && (td_data[3] == (code_v ^ code_h))
                    && (td_data[2] == (code_f ^ code_h))
                    && (td_data[1] == (code_f ^ code_v))
                    && (td_data[0] == (code_f ^ code_v ^ code_h));
        sav_start = code_det && code_ok && !code_h && !code_v;
    end

    // Byte delay line; a detected code squashes its three preamble bytes and the code byte itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0 <= 8'h00;
            d1 <= 8'h00;
            d2 <= 8'h00;
            d3 <= 8'h00;
            a0 <= 1'b0;
            a1 <= 1'b0;
            a2 <= 1'b0;
            a3 <= 1'b0;
        end else begin
            d0 <= td_data;
            d1 <= d0;
            d2 <= d1;
            d3 <= d2;
            a0 <= line_active && !code_det;
            a1 <= a0 && !code_det;
            a2 <= a1 && !code_det;
            a3 <= a2 && !code_det;
        end
    end

    // Timing state driven by valid EAV/SAV codes; a bad code only raises sync_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field       <= 1'b0;
            v_blank     <= 1'b0;
            line_active <= 1'b0;
            tv_y        <= 10'd0;
            y_clr_pend  <= 1'b1;
            sync_err    <= 1'b0;
        end else begin
            sync_err <= code_det && !code_ok;
            if (code_det && code_ok) begin
                field   <= code_f;
                v_blank <= code_v;
                if (code_h) begin
                    line_active <= 1'b0;
                    if (code_v) begin
                        y_clr_pend <= 1'b1;
                    end else if (tv_y < Y_SAT) begin
                        tv_y <= tv_y + 10'd1;
                    end
                end else if (!code_v) begin
                    line_active <= 1'b1;
                    if (y_clr_pend) begin
                        tv_y       <= 10'd0;
                        y_clr_pend <= 1'b0;
                    end
                end
            end
        end
    end

    // Emission of the oldest byte: Cb,Y0,Cr,Y1 phase walk, luma on odd phases; SAV restarts phase and x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_y     <= 8'h00;
            tv_x      <= 10'd0;
            phase     <= 2'd0;
            x_cnt     <= 10'd0;
        end else begin
            pix_valid <= 1'b0;
            if (a3) begin
                phase <= phase + 2'd1;
                if (phase[0]) begin
                    pix_valid <= 1'b1;
                    pix_y     <= d3;
                    tv_x      <= x_cnt;
                    if (x_cnt < X_SAT) begin
                        x_cnt <= x_cnt + 10'd1;
                    end
                end
            end
            // A new line wins over any in-flight increment on the same edge.
            if (sav_start) begin
                phase <= 2'd0;
                x_cnt <= 10'd0;
            end
        end
    end

endmodule

// File: tb/tb_tv_656_decoder.sv
// Purpose: self-checking bench for tv_656_decoder against a byte-stream reference model.
// Latency: model predicts every output after every clock edge.
// Backpressure: none; one byte is driven per clock.
module tb_tv_656_decoder;

    localparam int X_MAX = 1023;
    localparam int Y_MAX = 1023;
    localparam int MAXN  = 16000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] td_data = 8'h00;
    logic       pix_valid;
    logic [7:0] pix_y;
    logic [9:0] tv_x;
    logic [9:0] tv_y;
    logic       field;
    logic       v_blank;
    logic       line_active;
    logic       sync_err;

    tv_656_decoder #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .td_data     (td_data),
        .pix_valid   (pix_valid),
        .pix_y       (pix_y),
        .tv_x        (tv_x),
        .tv_y        (tv_y),
        .field       (field),
        .v_blank     (v_blank),
        .line_active (line_active),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the whole byte stream since reset, with an "active" flag per byte.
    logic [7:0] sb   [MAXN];
    bit         sact [MAXN];
    int n;
    int m_field, m_vb, m_la, m_y, m_yclr, m_serr;
    int m_pv, m_py, m_x;
    int m_ord, m_luma;

    int pulse_cnt;

    logic [7:0] vcodes [8] = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};

    // A code is valid when it equals the canonical byte rebuilt from its own F/V/H bits.
    function automatic bit code_valid(input logic [7:0] c);
        logic f, v, h;
        logic [7:0] canon;
        f = c[6];
        v = c[5];
        h = c[4];
        canon = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        return c == canon;
    endfunction

    task automatic model_reset();
        n = 0;
        m_field = 0; m_vb = 0; m_la = 0; m_y = 0; m_yclr = 1; m_serr = 0;
        m_pv = 0; m_py = 0; m_x = 0;
        m_ord = 0; m_luma = 0;
    endtask

    task automatic model_step(input logic [7:0] b);
        bit is_code;
        if (n >= MAXN) begin
            $display("FAIL model_capacity: got %0d expected below %0d", n, MAXN);
            $fatal(1, "stream too long");
        end
        sb[n] = b;
        is_code = (n >= 3) && (sb[n-3] == 8'hFF) && (sb[n-2] == 8'h00) && (sb[n-1] == 8'h00);
        sact[n] = (m_la != 0) && !is_code;
        if (is_code) begin
            sact[n-1] = 1'b0;
            sact[n-2] = 1'b0;
            sact[n-3] = 1'b0;
        end
        // Byte sampled four edges ago leaves the pipe now; odd ordinals since SAV are luma.
        m_pv = 0;
        if (n >= 4 && sact[n-4]) begin
            if (m_ord % 2 == 1) begin
                m_pv = 1;
                m_py = sb[n-4];
                m_x  = (m_luma > X_MAX) ? X_MAX : m_luma;
                m_luma++;
            end
            m_ord++;
        end
        m_serr = 0;
        if (is_code) begin
            if (code_valid(b)) begin
                m_field = b[6];
                m_vb    = b[5];
                if (b[4]) begin
                    m_la = 0;
                    if (b[5]) m_yclr = 1;
                    else if (m_y < Y_MAX) m_y++;
                end else if (!b[5]) begin
                    m_la = 1;
                    m_ord = 0;
                    m_luma = 0;
                    if (m_yclr != 0) begin
                        m_y = 0;
                        m_yclr = 0;
                    end
                end
            end else begin
                m_serr = 1;
            end
        end
        n++;
    endtask

    task automatic compare_all();
        check("pix_valid",   pix_valid,   m_pv);
        check("pix_y",       pix_y,       m_py);
        check("tv_x",        tv_x,        m_x);
        check("tv_y",        tv_y,        m_y);
        check("field",       field,       m_field);
        check("v_blank",     v_blank,     m_vb);
        check("line_active", line_active, m_la);
        check("sync_err",    sync_err,    m_serr);
        if (pix_valid) pulse_cnt++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_y"},     pix_y,     0);
        check({tag, "_tv_x"},      tv_x,      0);
        check({tag, "_tv_y"},      tv_y,      0);
        check({tag, "_field"},     field,     0);
        check({tag, "_v_blank"},   v_blank,   0);
        check({tag, "_line_act"},  line_active, 0);
        check({tag, "_sync_err"},  sync_err,  0);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        td_data = b;
        @(posedge clk);
        #1;
        model_step(b);
        compare_all();
    endtask

    task automatic send_code(input logic [7:0] c);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(c);
    endtask

    task automatic send_rand(input int len);
        for (int i = 0; i < len; i++) send(8'($urandom_range(254, 1)));
    endtask

    task automatic blank(input int len);
        for (int i = 0; i < len; i++) send((i % 2 == 0) ? 8'h80 : 8'h10);
    endtask

    // Reset asserted away from the clock edge, released just after a rising edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int first;
        int kind;
        logic [7:0] c;

        model_reset();
        #3;
        do_reset("rst0");

        // Idle, vertical-blank EAV and a blanking SAV that must not open a line.
        blank(20);
        send_code(8'hB6);
        blank(10);
        send_code(8'hAB);
        send_rand(12);
        check("sav_vblank_no_line", line_active, 0);

        // Full nominal line with counting luma pattern.
        send_code(8'h80);
        pulse_cnt = 0;
        first = -1;
        for (int i = 0; i < 1440; i++) begin
            send(8'(i % 256));
            if (pix_valid && first < 0) first = i;
        end
        send_code(8'h9D);
        check("first_pix_latency", first + 1, 6);
        check("line_pulses", pulse_cnt, 720);
        check("last_tv_x", tv_x, 719);

        // Vertical count across three lines after a V=1 EAV.
        send_code(8'hB6);
        blank(6);
        for (int l = 0; l < 3; l++) begin
            send_code(8'h80);
            send_rand(2 * $urandom_range(40, 16));
            send_code(8'h9D);
            blank(4);
        end
        check("tv_y_after_three", tv_y, 3);

        // Field 1 codes, then back to field 0 vertical blank.
        send_code(8'hDA);
        check("field_after_DA", field, 1);
        check("vblank_after_DA", v_blank, 0);
        send_code(8'hC7);
        send_rand(40);
        send_code(8'hDA);
        send_code(8'hB6);
        check("field_after_B6", field, 0);
        check("vblank_after_B6", v_blank, 1);

        // Protection error during an active line.
        send_code(8'h80);
        send_rand(21);
        send_code(8'h81);
        check("sync_err_pulse", sync_err, 1);
        check("err_keeps_line", line_active, 1);
        send(8'h55);
        check("sync_err_one_cycle", sync_err, 0);
        send_rand(30);
        send_code(8'h9D);

        // Randomized code/data mix, including invalid codes and back-to-back codes.
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(5, 0);
            case (kind)
                0: c = 8'h80;
                1: c = 8'h9D;
                2: c = vcodes[$urandom_range(7, 0)];
                3: c = 8'($urandom_range(255, 0));
                default: c = 8'h80;
            endcase
            send_code(c);
            send_rand($urandom_range(60, 0));
        end

        // Reset in the middle of an active line; nothing may come out until a new SAV.
        send_code(8'h80);
        send_rand(31);
        do_reset("rst_mid");
        pulse_cnt = 0;
        send_rand(40);
        check("no_pix_after_reset", pulse_cnt, 0);
        send_code(8'h9D);
        send_code(8'h80);
        send_rand(20);
        send_code(8'h9D);

        // Overlong line: tv_x saturates and holds until the next SAV.
        send_code(8'h80);
        send_rand(2200);
        check("tv_x_saturated", tv_x, X_MAX);
        send_code(8'h80);
        check("tv_x_hold_at_sav", tv_x, X_MAX);
        send_rand(8);
        send_code(8'h9D);
        blank(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
